// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: data width, gray conversion and
// the write-arbiter state encoding.
package fifo_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic {IDLE, BURST} arb_state_e;

    // Callers size-cast the result down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle: requester handshake, RAM write port and pointer
// exchange with the read domain.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int unsigned n    = 5,
    parameter int unsigned NREQ = 4
);

    logic [NREQ-1:0]        req;
    logic [DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic [n-1:0]           rptr_g;
    logic                   wen;
    logic [n-2:0]           waddr_g;
    logic [DATA_W-1:0]      wdata;
    logic [n-1:0]           wptr_g;
    logic                   wfull;

    modport master (
        output req, req_data, rptr_g,
        input  gnt, wen, waddr_g, wdata, wptr_g, wfull
    );

    modport slave (
        input  req, req_data, rptr_g,
        output gnt, wen, waddr_g, wdata, wptr_g, wfull
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for gray-coded pointers crossing clock domains.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side FIFO controller: round-robin/burst arbitration of NREQ requesters
// onto the single RAM write port, write pointer ownership and full flag.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned n        = 5,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAXBURST = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAXBURST + 1);
    localparam int unsigned AW = n - 1;

    arb_state_e        state;
    logic [IW-1:0]     owner, rr_ptr, winner, sel_idx;
    logic              win_valid;
    logic [CW-1:0]     cnt, cnt_inc;
    logic [NREQ-1:0]   gnt_c, gnt;
    logic              wen;
    logic [DATA_W-1:0] wdata_c;
    logic [n-1:0]      wbin, wbin_next, wgray_next, wptr_g, rq2, full_ptr;
    logic              wfull;

    sync_2ff #(
        .WIDTH (n)
    ) u_rsync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (bus.rptr_g),
        .q     (rq2)
    );

    // First requester at or after rr_ptr+1, cyclically.
    always_comb begin
        winner    = rr_ptr;
        win_valid = 1'b0;
        sel_idx   = rr_ptr;
        for (int k = 1; k <= int'(NREQ); k++) begin
            sel_idx = IW'((int'(rr_ptr) + k) % int'(NREQ));
            if (!win_valid && bus.req[sel_idx]) begin
                winner    = sel_idx;
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        unique case (state)
            IDLE:  if (!wfull && win_valid) gnt_c[winner] = 1'b1;
            BURST: if (!wfull && bus.req[owner]) gnt_c[owner] = 1'b1;
        endcase
    end

    // Grant is combinational, so it must be forced off while reset is held.
    assign gnt = wrst_n ? gnt_c : '0;
    assign wen = |gnt;

    always_comb begin
        wdata_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) wdata_c = bus.req_data[DATA_W*i +: DATA_W];
        end
    end

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            owner  <= '0;
            cnt    <= '0;
            rr_ptr <= IW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (!wfull && win_valid) begin
                        rr_ptr <= winner;
                        owner  <= winner;
                        cnt    <= CW'(1);
                        state  <= (MAXBURST > 1) ? BURST : IDLE;
                    end
                end
                BURST: begin
                    if (!bus.req[owner]) begin
                        state <= IDLE;
                    end else if (!wfull) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CW'(MAXBURST)) state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign wbin_next  = wbin + {{(n-1){1'b0}}, wen};
    assign wgray_next = n'(bin2gray(32'(wbin_next)));
    // Full when the next write pointer equals the read pointer with the top two bits inverted.
    assign full_ptr   = {~rq2[n-1:n-2], rq2[n-3:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr_g <= '0;
            wfull  <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wptr_g <= wgray_next;
            wfull  <= (wgray_next == full_ptr);
        end
    end

    // RAM address is the gray code of the low bits, not a slice of wptr_g.
    assign bus.waddr_g = AW'(bin2gray(32'(wbin[n-2:0])));
    assign bus.gnt     = gnt;
    assign bus.wen     = wen;
    assign bus.wdata   = wdata_c;
    assign bus.wptr_g  = wptr_g;
    assign bus.wfull   = wfull;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: one pure round-robin instance and one
// burst instance, expected beats queued when stimulus is applied.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int unsigned N    = 5;
    localparam int unsigned NREQ = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] data;
        logic [3:0] addr;
    } beat_t;

    logic wclk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.n(N), .NREQ(NREQ)) bus_a ();
    fifo_wr_arbiter_if #(.n(N), .NREQ(NREQ)) bus_b ();

    fifo_wr_arbiter #(.n(N), .NREQ(NREQ), .MAXBURST(1)) u_dut_rr (
        .wclk   (wclk),
        .wrst_n (rst_a),
        .bus    (bus_a)
    );

    fifo_wr_arbiter #(.n(N), .NREQ(NREQ), .MAXBURST(4)) u_dut_burst (
        .wclk   (wclk),
        .wrst_n (rst_b),
        .bus    (bus_b)
    );

    beat_t       q_a[$];
    beat_t       q_b[$];
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cnt_a;
    int unsigned cnt_b;
    logic [3:0]  samp_gnt_a, samp_gnt_b;
    logic        samp_wen_a, samp_wen_b;

    function automatic logic [3:0] gray4(input int unsigned v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] gray5(input int unsigned v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input int d, input int r);
        beat_t       b;
        logic [15:0] rd;
        rd     = (d == 0) ? bus_a.req_data : bus_b.req_data;
        b.gnt  = 4'(1 << r);
        b.data = rd[4*r +: 4];
        if (d == 0) begin
            b.addr = gray4(cnt_a);
            cnt_a++;
            q_a.push_back(b);
        end else begin
            b.addr = gray4(cnt_b);
            cnt_b++;
            q_b.push_back(b);
        end
    endtask

    task automatic sample_dut(input int d);
        logic [3:0] g, rq, dat, ad;
        logic       w, have;
        string      nm;
        beat_t      b;
        have = 1'b0;
        b    = '0;
        if (d == 0) begin
            g = bus_a.gnt; w = bus_a.wen; dat = bus_a.wdata; ad = bus_a.waddr_g;
            rq = bus_a.req; nm = "rr";
            samp_gnt_a = g; samp_wen_a = w;
            if (w && q_a.size() > 0) begin b = q_a.pop_front(); have = 1'b1; end
        end else begin
            g = bus_b.gnt; w = bus_b.wen; dat = bus_b.wdata; ad = bus_b.waddr_g;
            rq = bus_b.req; nm = "burst";
            samp_gnt_b = g; samp_wen_b = w;
            if (w && q_b.size() > 0) begin b = q_b.pop_front(); have = 1'b1; end
        end
        if (w && !have) begin
            check_val({nm, "_unexpected_wen"}, 32'(w), 32'(0));
        end else if (w) begin
            check_val({nm, "_gnt"}, 32'(g), 32'(b.gnt));
            check_val({nm, "_wdata"}, 32'(dat), 32'(b.data));
            check_val({nm, "_waddr_g"}, 32'(ad), 32'(b.addr));
        end else begin
            check_val({nm, "_gnt_when_idle"}, 32'(g), 32'(0));
        end
        check_val({nm, "_gnt_without_req"}, 32'(g & ~rq), 32'(0));
    endtask

    // Called at posedge+1; samples at posedge+4 and returns at the next posedge+1.
    task automatic step();
        #3;
        sample_dut(0);
        sample_dut(1);
        @(posedge wclk);
        #1;
    endtask

    task automatic check_reset(input string nm, input int d);
        if (d == 0) begin
            check_val({nm, "_gnt"}, 32'(bus_a.gnt), 32'(0));
            check_val({nm, "_wen"}, 32'(bus_a.wen), 32'(0));
            check_val({nm, "_wptr_g"}, 32'(bus_a.wptr_g), 32'(0));
            check_val({nm, "_waddr_g"}, 32'(bus_a.waddr_g), 32'(0));
            check_val({nm, "_wfull"}, 32'(bus_a.wfull), 32'(0));
        end else begin
            check_val({nm, "_gnt"}, 32'(bus_b.gnt), 32'(0));
            check_val({nm, "_wen"}, 32'(bus_b.wen), 32'(0));
            check_val({nm, "_wptr_g"}, 32'(bus_b.wptr_g), 32'(0));
            check_val({nm, "_waddr_g"}, 32'(bus_b.waddr_g), 32'(0));
            check_val({nm, "_wfull"}, 32'(bus_b.wfull), 32'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned rd;
        n_checks = 0;
        n_fail   = 0;
        cnt_a    = 0;
        cnt_b    = 0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        bus_a.req      = 4'b1111;
        bus_b.req      = 4'b1111;
        bus_a.req_data = 16'hDCBA;
        bus_b.req_data = 16'h9735;
        bus_a.rptr_g   = '0;
        bus_b.rptr_g   = '0;

        // Reset with every request high
        #12;
        check_reset("reset_rr", 0);
        check_reset("reset_burst", 1);
        bus_b.req = '0;
        @(posedge wclk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Pure round-robin, all requesters
        for (int i = 0; i < 6; i++) push_beat(0, i % 4);
        repeat (6) step();
        check_val("rr_drained", 32'(q_a.size()), 32'(0));
        bus_a.req = '0;
        step();

        // Bursts of four alternating between requesters 0 and 1
        bus_b.req = 4'b0011;
        for (int i = 0; i < 10; i++) push_beat(1, (i / 4) % 2);
        repeat (10) step();
        bus_b.req = 4'b0010;
        step();
        check_val("burst_bubble_gnt", 32'(samp_gnt_b), 32'(0));
        push_beat(1, 1);
        step();
        bus_b.req = '0;
        step();
        check_val("burst_drained", 32'(q_b.size()), 32'(0));

        // Fill from empty with read pointer parked at 0
        rst_a = 1'b0;
        @(posedge wclk);
        #1;
        rst_a = 1'b1;
        cnt_a = 0;
        bus_a.req = 4'b0100;
        for (int i = 0; i < 16; i++) push_beat(0, 2);
        repeat (16) step();
        check_val("fill_wfull", 32'(bus_a.wfull), 32'(1));
        check_val("fill_wptr_g", 32'(bus_a.wptr_g), 32'(gray5(16)));
        check_val("fill_waddr_g", 32'(bus_a.waddr_g), 32'(gray4(16)));
        step();
        check_val("full_no_gnt", 32'(samp_gnt_a), 32'(0));
        check_val("full_no_wen", 32'(samp_wen_a), 32'(0));

        // Read side frees one slot; full must hold through the synchroniser
        bus_a.rptr_g = gray5(1);
        step();
        check_val("release_edge1_wfull", 32'(bus_a.wfull), 32'(1));
        step();
        check_val("release_edge2_wfull", 32'(bus_a.wfull), 32'(1));
        step();
        check_val("release_edge3_wfull", 32'(bus_a.wfull), 32'(0));
        push_beat(0, 2);
        step();
        check_val("refull_wfull", 32'(bus_a.wfull), 32'(1));
        check_val("refull_wptr_g", 32'(bus_a.wptr_g), 32'(gray5(17)));
        step();
        check_val("refull_no_wen", 32'(samp_wen_a), 32'(0));

        // 40 writes across the pointer wrap with a lagging model reader
        rst_a = 1'b0;
        @(posedge wclk);
        #1;
        rst_a = 1'b1;
        cnt_a = 0;
        bus_a.rptr_g = '0;
        bus_a.req = 4'b0010;
        for (int k = 1; k <= 40; k++) begin
            push_beat(0, 1);
            step();
            rd = (k >= 4) ? k - 4 : 0;
            bus_a.rptr_g = gray5(rd);
            if (k == 31) check_val("wrap_wptr_31", 32'(bus_a.wptr_g), 32'(5'b10000));
            if (k == 32) check_val("wrap_wptr_32", 32'(bus_a.wptr_g), 32'(5'b00000));
        end
        check_val("wrap_wptr_40", 32'(bus_a.wptr_g), 32'(gray5(40)));
        check_val("wrap_wfull", 32'(bus_a.wfull), 32'(0));
        bus_a.req = '0;
        step();

        // Reset asserted during beat 2 of a burst
        rst_b = 1'b0;
        @(posedge wclk);
        #1;
        rst_b = 1'b1;
        cnt_b = 0;
        bus_b.req = 4'b0001;
        push_beat(1, 0);
        step();
        #1;
        check_val("midburst_gnt", 32'(bus_b.gnt), 32'(4'b0001));
        check_val("midburst_wptr_g", 32'(bus_b.wptr_g), 32'(gray5(1)));
        rst_b = 1'b0;
        #1;
        check_reset("midburst_reset", 1);
        @(posedge wclk);
        #1;
        check_val("midburst_hold_wptr_g", 32'(bus_b.wptr_g), 32'(0));
        rst_b = 1'b1;
        cnt_b = 0;
        push_beat(1, 0);
        step();
        bus_b.req = '0;
        step();

        check_val("final_sb_rr_empty", 32'(q_a.size()), 32'(0));
        check_val("final_sb_burst_empty", 32'(q_b.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side controller for the async FIFO dual-port RAM. It shares the single write port among NREQ requesters using round-robin arbitration with optional bursts. It owns the write pointer, drives the RAM's gray-coded write address and write enable, and generates the full flag from a synchronised copy of the read-domain gray pointer. It sits entirely in the wclk domain.

Parameters:
n, 5, pointer width in bits; RAM depth is 2**(n-1) words; RAM address is n-1 bits.
NREQ, 4, number of requesters (2..8).
MAXBURST, 4, maximum consecutive beats per grant (1 = pure round-robin).

Ports:
wclk  in  1  write-domain clock.
wrst_n  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester request; held high while data is valid.
req_data  in  4*NREQ  requester i's data in bits [4i+3:4i].
gnt  out  NREQ  one-hot grant; a beat transfers in any cycle where gnt[i]=1.
rptr_g  in  n  read-domain gray pointer; asynchronous to wclk.
wen  out  1  RAM write enable.
waddr_g  out  n-1  RAM gray write address.
wdata  out  4  RAM write data.
wptr_g  out  n  gray write pointer, exported to the read domain.
wfull  out  1  FIFO full, registered.

Behaviour:
- One clock; reset is asynchronous and active-low (wrst_n); clock is wclk.
- Reset values:
  - wbin (n-bit binary write pointer) = 0, wptr_g = 0, wfull = 0.
  - Synchroniser flops = 0, state = IDLE, burst count = 0, owner = 0, rr_ptr = NREQ-1.
  - While wrst_n = 0, gnt = 0 and wen = 0.
- Synchroniser: two flops carry rptr_g into wclk; the second-stage output is rq2.
- Pointers:
  - wptr_g = wbin ^ (wbin >> 1), registered.
  - waddr_g = gray of wbin[n-2:0], i.e. wbin[n-2:0] ^ (wbin[n-2:0] >> 1). This is NOT the low bits of wptr_g.
  - wbin increments by 1 on every cycle with wen = 1 and wraps modulo 2**n.
- Full flag:
  - wfull is registered: wfull <= (gray(wbin + wen) == {~rq2[n-1:n-2], rq2[n-3:0]}).
  - wfull deasserts no earlier than two wclk edges after rptr_g changes, plus one register stage.
- Write path, combinational from state and req:
  - wen = |gnt.
  - wdata = req_data slice of the granted requester, or 0 when there is no grant.
  - gnt[i] is only ever asserted while req[i] = 1.
- State machine: IDLE, BURST.
  - IDLE:
    - If wfull = 0 and |req, the winner is the first i with req[i] = 1, searching cyclically from rr_ptr+1.
    - gnt = onehot(winner); rr_ptr <= winner; owner <= winner; cnt <= 1.
    - Go to BURST if MAXBURST > 1, otherwise stay in IDLE.
    - If wfull = 1 or no request: no grant, stay in IDLE.
  - BURST:
    - req[owner] = 1 and wfull = 0: gnt[owner] = 1; cnt <= cnt+1; go to IDLE when cnt+1 == MAXBURST.
    - req[owner] = 1 and wfull = 1: no grant; hold state, owner and cnt.
    - req[owner] = 0: no grant this cycle (one bubble), go to IDLE.
- Boundary conditions:
  - Full: no write occurs; the requester simply waits with req held.
  - Wrap: wbin rolls over from 2**n-1 to 0; the gray sequences stay single-bit-change.
  - Reset mid-burst: everything returns to reset values immediately; no partial beat is written.
  - Simultaneous write and read-pointer movement: wfull is evaluated from the post-increment pointer against the rq2 value of that same cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W = 4;
  - function bin2gray;
  - arbiter state enum {IDLE, BURST}.
- One sub-module: sync_2ff (width parameter) for the rptr_g synchroniser, reused by the read side for wptr_g.

Test Plan:
- Reset: assert wrst_n = 0 with req = 4'b1111 -> gnt = 0, wen = 0, wptr_g = 0, waddr_g = 0, wfull = 0; after release the first grant goes to requester 0.
- Fill (n = 5, MAXBURST = 1, rptr_g held at 0), req[2] continuously -> 16 writes with waddr_g = 0,1,3,2,6,... and wfull = 1 after the 16th beat; 17th cycle gnt = 0, wen = 0.
- Round-robin (MAXBURST = 1, all four req high) -> grants in order 0,1,2,3,0,1 and wdata tracks each requester's slice.
- Burst (MAXBURST = 4, req[0] and req[1] high) -> four beats to 0, four beats to 1, then 0 again; dropping req[0] after beat 2 -> one idle cycle, then grant to 1.
- Full release: while full, step rptr_g from 0 to 1 (gray) -> wfull clears 3 wclk edges later; exactly one further write is accepted before full returns.
- Wrap and reset-mid-burst: 40 writes with a model reader -> wptr_g wraps 10000 -> 00000 correctly; assert wrst_n during beat 2 of a burst -> outputs return to reset values asynchronously.
